// File: rtl/if_id_queue_pkg.sv
// ============================================================================
// if_id_queue_pkg: default sizing and entry-width helper shared by the
// IF/ID queue files.  Rev 1.0
// ============================================================================
`default_nettype none

package if_id_queue_pkg;

    localparam int IF_ID_DATA_W = 32;
    localparam int IF_ID_PRED_W = 2;
    localparam int IF_ID_DEPTH  = 4;

    // Stored entry is {pred, pc_plus4, pc, instr}
    function automatic int if_id_entry_w(input int data_w, input int pred_w);
        return 3 * data_w + pred_w;
    endfunction

    localparam int IF_ID_ENTRY_W = if_id_entry_w(IF_ID_DATA_W, IF_ID_PRED_W);

endpackage

`default_nettype wire

// File: rtl/if_id_queue_if.sv
// ============================================================================
// if_id_queue_if: fetch-side push and decode-side head signals of the queue.
// Rev 1.0
// ============================================================================
`default_nettype none

interface if_id_queue_if
    import if_id_queue_pkg::*;
#(
    parameter int DATA_W = IF_ID_DATA_W,
    parameter int PRED_W = IF_ID_PRED_W,
    parameter int DEPTH  = IF_ID_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) ();

    logic              valid_if;
    logic [DATA_W-1:0] instr1_if;
    logic [DATA_W-1:0] instr_pc_if;
    logic [DATA_W-1:0] instr_pc_plus4_if;
    logic [PRED_W-1:0] pred_if;
    logic              ready_out;
    logic              stall;
    logic              flush;
    logic              valid_out;
    logic [DATA_W-1:0] instr1_out;
    logic [DATA_W-1:0] instr_pc_out;
    logic [DATA_W-1:0] instr_pc_plus4;
    logic [PRED_W-1:0] pred_out;
    logic [CNT_W-1:0]  count_out;

    // Pipeline side drives fetch data and ID control
    modport master (
        output valid_if, instr1_if, instr_pc_if, instr_pc_plus4_if, pred_if,
        output stall, flush,
        input  ready_out, valid_out, instr1_out, instr_pc_out, instr_pc_plus4,
        input  pred_out, count_out
    );

    modport slave (
        input  valid_if, instr1_if, instr_pc_if, instr_pc_plus4_if, pred_if,
        input  stall, flush,
        output ready_out, valid_out, instr1_out, instr_pc_out, instr_pc_plus4,
        output pred_out, count_out
    );

endinterface

`default_nettype wire

// File: rtl/if_id_fifo_ctrl.sv
// ============================================================================
// if_id_fifo_ctrl: read/write pointers, occupancy count and push/pop/flush
// arbitration for the IF/ID queue.  Rev 1.0
// ============================================================================
`default_nettype none

module if_id_fifo_ctrl
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH  = IF_ID_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             valid_in,
    input  wire logic             stall,
    input  wire logic             flush,
    output logic                  ready,
    output logic                  valid,
    output logic                  push,
    output logic                  pop,
    output logic [PTR_W-1:0]      wr_ptr,
    output logic [PTR_W-1:0]      rd_ptr,
    output logic [CNT_W-1:0]      count
);

    // Status comes from the count register only, so ready never depends
    // combinationally on stall/flush/valid_in; a full queue refuses pushes
    // even when a pop happens in the same cycle.
    assign ready = (count != CNT_W'(DEPTH));
    assign valid = (count != '0);
    assign push  = valid_in & ready & ~flush;
    assign pop   = valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
// ============================================================================
// if_id_queue: DEPTH-entry elastic fetch-to-decode buffer with valid/ready
// handshake and mispredict flush.  Rev 1.0
// ============================================================================
`default_nettype none

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DATA_W = IF_ID_DATA_W,
    parameter int DEPTH  = IF_ID_DEPTH,
    parameter int PRED_W = IF_ID_PRED_W
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    if_id_queue_if.slave  bus
);

    localparam int ENTRY_W = if_id_entry_w(DATA_W, PRED_W);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic               w_ready;
    logic [PTR_W-1:0]   w_wr_ptr;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;

    if_id_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (bus.valid_if),
        .stall    (bus.stall),
        .flush    (bus.flush),
        .ready    (w_ready),
        .valid    (w_valid),
        .push     (w_push),
        .pop      (w_pop),
        .wr_ptr   (w_wr_ptr),
        .rd_ptr   (w_rd_ptr),
        .count    (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= {bus.pred_if, bus.instr_pc_plus4_if,
                                bus.instr_pc_if, bus.instr1_if};
        end
    end

    // Stale storage past a flush is hidden by forcing the head to zero
    assign w_head = w_valid ? r_mem[w_rd_ptr] : '0;

    assign bus.ready_out      = w_ready;
    assign bus.valid_out      = w_valid;
    assign bus.count_out      = w_count;
    assign bus.instr1_out     = w_head[DATA_W-1:0];
    assign bus.instr_pc_out   = w_head[2*DATA_W-1:DATA_W];
    assign bus.instr_pc_plus4 = w_head[3*DATA_W-1:2*DATA_W];
    assign bus.pred_out       = w_head[ENTRY_W-1:3*DATA_W];

    // w_pop is consumed only by the pointer logic inside the controller
    logic w_unused;
    assign w_unused = w_pop;

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ============================================================================
// tb_if_id_queue: directed scoreboard bench for the IF/ID queue.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_id_queue;

    localparam int DATA_W = 32;
    localparam int PRED_W = 2;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [PRED_W-1:0] pred;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } ent_t;

    logic clk;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;
    ent_t sb[$];

    if_id_queue_if #(.DATA_W(DATA_W), .PRED_W(PRED_W), .DEPTH(DEPTH)) bus ();

    if_id_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PRED_W (PRED_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare all outputs against the scoreboard's current state
    task automatic check_outputs(input string tag);
        ent_t exp_head;
        ent_t obs_head;
        exp_head = (sb.size() != 0) ? sb[0] : '0;
        obs_head = {bus.pred_out, bus.instr_pc_plus4, bus.instr_pc_out, bus.instr1_out};
        check({tag, ".ready"}, 128'(bus.ready_out), 128'(sb.size() != DEPTH));
        check({tag, ".count"}, 128'(bus.count_out), 128'(sb.size()));
        check({tag, ".valid"}, 128'(bus.valid_out), 128'(sb.size() != 0));
        check({tag, ".head"},  128'(obs_head),      128'(exp_head));
    endtask

    // One clock: drive inputs, check at negedge, then update the model at the edge
    task automatic cycle(input string tag, input logic v, input logic [DATA_W-1:0] pc,
                         input logic st, input logic fl);
        ent_t e;
        logic do_push;
        logic do_pop;
        e.instr = pc ^ 32'h2400_0000;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.pred  = pc[3:2];
        bus.valid_if          = v;
        bus.instr1_if         = e.instr;
        bus.instr_pc_if       = e.pc;
        bus.instr_pc_plus4_if = e.pc4;
        bus.pred_if           = e.pred;
        bus.stall             = st;
        bus.flush             = fl;
        @(negedge clk);
        check_outputs(tag);
        do_push = v && (sb.size() != DEPTH) && !fl;
        do_pop  = (sb.size() != 0) && !st && !fl;
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back(e);
        end
    endtask

    initial begin
        ent_t first;
        rst_n = 1'b0;
        bus.valid_if = 1'b0; bus.instr1_if = '0; bus.instr_pc_if = '0;
        bus.instr_pc_plus4_if = '0; bus.pred_if = '0; bus.stall = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // 1: single push into empty queue, exact field values
        first.instr = 32'h2402_000A; first.pc = 32'hBFC0_0000;
        first.pc4 = 32'hBFC0_0004; first.pred = 2'b01;
        bus.valid_if = 1'b1; bus.instr1_if = first.instr; bus.instr_pc_if = first.pc;
        bus.instr_pc_plus4_if = first.pc4; bus.pred_if = first.pred;
        @(negedge clk);
        check_outputs("t1.pre");
        @(posedge clk);
        #1;
        sb.push_back(first);
        cycle("t1.head", 1'b0, 32'h0, 1'b0, 1'b0);

        // 2: stalled fill, fifth held by IF
        for (int i = 0; i < 5; i++) cycle("t2.fill", 1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
        cycle("t2.full", 1'b1, 32'h110, 1'b1, 1'b0);

        // 3: one-cycle release from full; no push while full
        cycle("t3.pop", 1'b1, 32'h110, 1'b0, 1'b0);
        cycle("t3.after", 1'b0, 32'h0, 1'b1, 1'b0);

        // 4: bring count to 2, then push+pop across pointer wrap
        cycle("t4.drain", 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("t4.stream", 1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
        cycle("t4.end", 1'b1, 32'h500, 1'b1, 1'b0);

        // 5: flush with a concurrent push
        cycle("t5.flush", 1'b1, 32'h200, 1'b0, 1'b1);
        cycle("t5.post", 1'b1, 32'h300, 1'b1, 1'b0);
        cycle("t5.head", 1'b0, 32'h0, 1'b0, 1'b0);
        cycle("t5.empty", 1'b0, 32'h0, 1'b0, 1'b0);

        // 6: asynchronous reset with entries in flight
        for (int i = 0; i < 3; i++) cycle("t6.fill", 1'b1, 32'h600 + 32'(4 * i), 1'b1, 1'b0);
        bus.valid_if = 1'b0;
        bus.stall = 1'b0;
        #1;
        check("t6.count_pre", 128'(bus.count_out), 128'(3));
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_outputs("t6.rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("t6.fresh", 1'b1, 32'h700, 1'b1, 1'b0);
        cycle("t6.head", 1'b0, 32'h0, 1'b0, 1'b0);
        cycle("t6.empty", 1'b0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
